// File: rtl/eci_pkg.sv
// Shared ECI definitions: word/packet/chunk dimensions, container types and the
// reassembler state encoding.
package eci_pkg;
  localparam int ECI_WORD_W  = 64;
  localparam int ECI_PKT_MAX = 17;
  localparam int ECI_VC_MAX  = 7;

  typedef logic [ECI_PKT_MAX-1:0][ECI_WORD_W-1:0] eci_pkt_t;
  typedef logic [ECI_VC_MAX-1:0][ECI_WORD_W-1:0]  eci_vc_t;

  typedef enum logic {ACCUM, OUT} vc2pkt_state_t;
endpackage

// File: rtl/axis_eci_vc_to_pkt_2vc.sv
// Receive-side reassembler: concatenates VC chunks (word 0 first) into one ECI
// packet, saturating at PKT_SIZE words and flagging the overflow for one cycle.
module axis_eci_vc_to_pkt_2vc
  import eci_pkg::*;
#(
  parameter int WORD_WIDTH     = ECI_WORD_W,
  parameter int PKT_SIZE       = ECI_PKT_MAX,
  parameter int PKT_SIZE_WIDTH = $clog2(PKT_SIZE) + ((PKT_SIZE % 2) == 0),
  parameter int VC_SIZE        = ECI_VC_MAX,
  parameter int VC_SIZE_WIDTH  = $clog2(VC_SIZE) + ((VC_SIZE % 2) == 0)
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [VC_SIZE*WORD_WIDTH-1:0]    vc_pkt_i,
  input  logic [VC_SIZE_WIDTH-1:0]         vc_pkt_size_i,
  input  logic                             vc_pkt_last_i,
  input  logic                             vc_pkt_valid_i,
  output logic                             vc_pkt_ready_o,
  output logic [PKT_SIZE*WORD_WIDTH-1:0]   eci_pkt_o,
  output logic [PKT_SIZE_WIDTH-1:0]        eci_pkt_size_o,
  output logic                             eci_pkt_valid_o,
  input  logic                             eci_pkt_ready_i,
  output logic                             err_ovf_o
);
  localparam logic [PKT_SIZE_WIDTH:0] PKT_MAX_W = (PKT_SIZE_WIDTH+1)'(PKT_SIZE);

  vc2pkt_state_t                         state_q, state_d;
  logic [PKT_SIZE_WIDTH-1:0]             cnt_q, cnt_d;
  logic [PKT_SIZE-1:0][WORD_WIDTH-1:0]   buf_q, buf_d;
  logic [PKT_SIZE_WIDTH-1:0]             size_q, size_d;
  logic                                  ovf_q, ovf_d;

  logic [VC_SIZE-1:0][WORD_WIDTH-1:0]    vc_w;
  logic [PKT_SIZE_WIDTH:0]               sum, nxt;
  logic                                  vc_hs;

  function automatic logic [PKT_SIZE_WIDTH:0] sat_len(input logic [PKT_SIZE_WIDTH:0] s);
    return (s > PKT_MAX_W) ? PKT_MAX_W : s;
  endfunction

  assign vc_w  = vc_pkt_i;
  // Sum is one bit wider than the count so 17+7 cannot wrap before saturation.
  assign sum   = {1'b0, cnt_q} + (PKT_SIZE_WIDTH+1)'(vc_pkt_size_i);
  assign nxt   = sat_len(sum);
  assign vc_hs = vc_pkt_valid_i && vc_pkt_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    size_d  = size_q;
    ovf_d   = 1'b0;
    case (state_q)
      ACCUM: begin
        if (vc_hs) begin
          for (int j = 0; j < PKT_SIZE; j++) begin
            int off;
            off = j - int'(cnt_q);
            if (off >= 0 && off < int'(vc_pkt_size_i) && off < VC_SIZE)
              buf_d[j] = vc_w[off];
          end
          ovf_d = (sum > PKT_MAX_W);
          if (vc_pkt_last_i) begin
            cnt_d = '0;
            // An empty packet is dropped: nothing written, no output.
            if (nxt != '0) begin
              size_d  = nxt[PKT_SIZE_WIDTH-1:0];
              state_d = OUT;
            end
          end else begin
            cnt_d = nxt[PKT_SIZE_WIDTH-1:0];
          end
        end
      end
      OUT: begin
        if (eci_pkt_ready_i) begin
          buf_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      buf_q   <= '0;
      size_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      size_q  <= size_d;
      ovf_q   <= ovf_d;
    end
  end

  assign vc_pkt_ready_o  = aresetn && (state_q == ACCUM);
  assign eci_pkt_valid_o = (state_q == OUT);
  assign eci_pkt_o       = buf_q;
  assign eci_pkt_size_o  = size_q;
  assign err_ovf_o       = ovf_q;
endmodule
